// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the iterative shifter: FSM encoding,
// direction codes and default geometry.
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_AMT_W = 5;
    localparam int DEFAULT_STEP  = 1;

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-step shifter: moves the word by k positions left or
// right, filling vacated right-shift bits with fill and left-shift bits with zero.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AMT_W = DEFAULT_AMT_W
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] k,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] fill_mask;

    // Ones in the top k positions: exactly the bits a right shift vacates.
    assign fill_mask = ~({WIDTH{1'b1}} >> k);

    always_comb begin
        result = '0;
        if (dir == DIR_RIGHT) begin
            result = (data >> k) | (fill ? fill_mask : '0);
        end else begin
            result = data << k;
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle left/right shifter moving STEP bits per clock with valid/ready
// on both sides. Define SEQ_SHIFTER_ARITH_EN to add shift_arith (sign-fill right shifts).
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. Once
// out_valid is high, shifted_data stays stable until that transfer.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AMT_W = DEFAULT_AMT_W,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_data,
    input  logic [AMT_W-1:0] shift_amount,
    input  logic             shift_dir,
`ifdef SEQ_SHIFTER_ARITH_EN
    input  logic             shift_arith,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifted_data,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    shift_state_t     state_q, state_d;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] step_data;
    logic [AMT_W-1:0] remaining_q;
    logic [AMT_W-1:0] k;
    logic             dir_q;
    logic             fill;
    logic             accept;
    logic             last_step;

    assign accept    = in_valid && in_ready;
    assign k         = (remaining_q < STEP_AMT) ? remaining_q : STEP_AMT;
    assign last_step = (remaining_q == k);

`ifdef SEQ_SHIFTER_ARITH_EN
    logic arith_q;

    // The MSB never changes during an arithmetic right shift, so it is the sign.
    assign fill = arith_q && (dir_q == DIR_RIGHT) && work_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            arith_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            arith_q <= shift_arith;
        end
    end
`else
    assign fill = 1'b0;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data   (work_q),
        .k      (k),
        .dir    (dir_q),
        .fill   (fill),
        .result (step_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (shift_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

    // shifted_data is only written on entry to DONE so it keeps the last
    // result through IDLE and the next operation's SHIFT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q       <= '0;
            dir_q        <= DIR_LEFT;
            remaining_q  <= '0;
            shifted_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q      <= input_data;
                        dir_q       <= shift_dir;
                        remaining_q <= shift_amount;
                        if (shift_amount == '0) begin
                            shifted_data <= input_data;
                        end
                    end
                end
                SHIFT: begin
                    work_q      <= step_data;
                    remaining_q <= remaining_q - k;
                    if (last_step) begin
                        shifted_data <= step_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
